i2c_burst_master: RTL and testbench

I2C_BURST_MASTER -- requirements
Module: i2c_burst_master

---
 rtl/i2c_burst_master.sv | 149 ++++++++++++++
 tb/tb_i2c_burst_master.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_burst_master.sv
// Byte-level open-drain I2C master: START / repeated START, write, read, STOP.
// Define I2C_CLK_STRETCH_EN to let slaves stretch SCL by holding it low.
module i2c_burst_master #(
   parameter int SYS_CLK_HZ = 100_000_000,
   parameter int SCL_HZ     = 100_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       i2c_en,
   input  logic       i2c_start,
   input  logic       i2c_stop,
   input  logic       rw,
   input  logic       i2c_ack,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   output logic       tx_done,
   output logic [7:0] rx_data,
   output logic       rx_done,
   output logic       ack_err,
   output logic       busy,
   inout  wire        SDA,
   inout  wire        SCL
);
   localparam int CLK_DIV = SYS_CLK_HZ / (4 * SCL_HZ);
   localparam int CW      = (CLK_DIV < 2) ? 1 : $clog2(CLK_DIV);

   generate
      if (CLK_DIV < 2) begin : g_div_check
         $error("i2c_burst_master: CLK_DIV must be at least 2");
      end
   endgenerate

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] START = 3'd1;
   localparam logic [2:0] DATA  = 3'd2;
   localparam logic [2:0] ACK   = 3'd3;
   localparam logic [2:0] HOLD  = 3'd4;
   localparam logic [2:0] STOP  = 3'd5;

   logic [2:0]    state;
   logic [CW-1:0] cnt;
   logic [1:0]    q;
   logic [2:0]    bitn;
   logic [7:0]    sh;
   logic          rd;
   logic          ack_bit;
   logic          sda_o;
   logic          scl_o;
   logic          accept;
   logic          adv;
   logic          last;

   assign SDA      = sda_o ? 1'bz : 1'b0;
   assign SCL      = scl_o ? 1'bz : 1'b0;
   assign tx_ready = (state == IDLE) || (state == HOLD);
   assign accept   = i2c_en && tx_ready && !(i2c_start && i2c_stop);
   assign last     = (cnt == CW'(CLK_DIV - 1));

`ifdef I2C_CLK_STRETCH_EN
   // Freeze while SCL is released by us but still held low by a slave.
   assign adv = !(scl_o && !SCL);
`else
   assign adv = 1'b1;
`endif

   always_ff @(posedge clk) begin
      tx_done <= 1'b0;
      rx_done <= 1'b0;
      if (reset) begin
         state   <= IDLE;
         cnt     <= '0;
         q       <= '0;
         bitn    <= '0;
         sh      <= '0;
         rd      <= 1'b0;
         ack_bit <= 1'b1;
         sda_o   <= 1'b1;
         scl_o   <= 1'b1;
         rx_data <= '0;
         ack_err <= 1'b0;
         busy    <= 1'b0;
      end else if (tx_ready) begin
         cnt <= '0;
         q   <= '0;
         if (accept && i2c_start) begin
            // From HOLD this releases SDA first; SCL stays as it is.
            state   <= START;
            busy    <= 1'b1;
            ack_err <= 1'b0;
            sda_o   <= 1'b1;
         end else if (accept && state == HOLD && i2c_stop) begin
            state <= STOP;
            sda_o <= 1'b0;
         end else if (accept && state == HOLD) begin
            state   <= DATA;
            bitn    <= '0;
            sh      <= tx_data;
            rd      <= rw;
            ack_bit <= i2c_ack;
            sda_o   <= rw | tx_data[7];
         end
      end else if (adv) begin
         if (!last) begin
            cnt <= cnt + CW'(1);
         end else begin
            cnt <= '0;
            q   <= q + 2'd1;
            unique case (q)
               2'd0: scl_o <= 1'b1;
               2'd1: begin
                  if (state == START) sda_o <= 1'b0;
                  if (state == STOP)  sda_o <= 1'b1;
                  if (state == DATA)  sh <= {sh[6:0], SDA};
                  if (state == ACK && !rd && SDA) ack_err <= 1'b1;
               end
               2'd2: if (state != STOP) scl_o <= 1'b0;
               default: begin
                  unique case (state)
                     START: state <= HOLD;
                     STOP: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                     end
                     DATA: begin
                        if (bitn == 3'd7) begin
                           state <= ACK;
                           sda_o <= !rd | ack_bit;
                        end else begin
                           bitn  <= bitn + 3'd1;
                           sda_o <= rd | sh[7];
                        end
                     end
                     ACK: begin
                        state <= HOLD;
                        if (rd) begin
                           rx_data <= sh;
                           rx_done <= 1'b1;
                        end else begin
                           tx_done <= 1'b1;
                        end
                     end
                     default: state <= IDLE;
                  endcase
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_i2c_burst_master.sv
// Bench for i2c_burst_master: command table, slave model and byte scoreboard.
module tb_i2c_burst_master;
   typedef struct {
      logic       st;
      logic       sp;
      logic       rw;
      logic       ak;
      logic       nack;
      logic       err;
      logic [7:0] d;
   } vec_t;

   logic       clk = 0;
   logic       reset = 1;
   logic       i2c_en = 0;
   logic       i2c_start = 0;
   logic       i2c_stop = 0;
   logic       rw = 0;
   logic       i2c_ack = 0;
   logic [7:0] tx_data = 0;
   logic       tx_ready;
   logic       tx_done;
   logic [7:0] rx_data;
   logic       rx_done;
   logic       ack_err;
   logic       busy;
   wire        SDA;
   wire        SCL;
   logic       slv_sda = 0;
   logic       slv_scl = 0;
   int         cyc = 0;
   int         st_at = -1;
   int         total = 0;
   int         bad = 0;
   logic [7:0] sb[$];

   pullup (SDA);
   pullup (SCL);
   assign SDA = slv_sda ? 1'b0 : 1'bz;
   assign SCL = slv_scl ? 1'b0 : 1'bz;

   i2c_burst_master #(
      .SYS_CLK_HZ(100_000_000),
      .SCL_HZ(100_000)
   ) dut (
      .clk(clk),
      .reset(reset),
      .i2c_en(i2c_en),
      .i2c_start(i2c_start),
      .i2c_stop(i2c_stop),
      .rw(rw),
      .i2c_ack(i2c_ack),
      .tx_data(tx_data),
      .tx_ready(tx_ready),
      .tx_done(tx_done),
      .rx_data(rx_data),
      .rx_done(rx_done),
      .ack_err(ack_err),
      .busy(busy),
      .SDA(SDA),
      .SCL(SCL)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Slave clock stretch: hold SCL low through bit 4's release plus 500 clocks.
   always @(negedge clk) begin
      if (st_at >= 0)
         slv_scl = (cyc >= st_at + 4100) && (cyc < st_at + 4750);
      else
         slv_scl = 1'b0;
   end

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, got, exp);
      end
   endtask

   task automatic wait_scl(input logic lvl, output bit ok);
      ok = 0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (SCL === lvl) begin
            ok = 1;
            break;
         end
      end
   endtask

   task automatic issue(input logic st, input logic sp, input logic r,
                        input logic ak, input logic [7:0] d,
                        output int t0);
      int n;
      n = 0;
      while (!tx_ready && n < 20000) begin
         @(negedge clk);
         n++;
      end
      i2c_en = 1; i2c_start = st; i2c_stop = sp;
      rw = r; i2c_ack = ak; tx_data = d;
      @(negedge clk);
      i2c_en = 0; i2c_start = 0; i2c_stop = 0;
      t0 = cyc;
   endtask

   task automatic wait_ready(output bit ok, output bit fell,
                             output bit dropped);
      logic ps;
      ps = SDA;
      ok = 0; fell = 0; dropped = 0;
      for (int i = 0; i < 5000; i++) begin
         if (tx_ready) begin
            ok = 1;
            break;
         end
         if (!busy) dropped = 1;
         @(negedge clk);
         if (ps === 1'b1 && SDA === 1'b0 && SCL === 1'b1) fell = 1;
         ps = SDA;
      end
   endtask

   task automatic do_byte(input vec_t v, input int extra);
      int t0;
      int n;
      bit ok;
      bit all;
      logic [7:0] cap;
      logic [7:0] e;
      all = 1; cap = 0;
      issue(v.st, v.sp, v.rw, v.ak, v.d, t0);
      chk("data_ready_drop", tx_ready, 0);
      sb.push_back(v.d);
      if (extra > 0) st_at = t0;
      for (int i = 0; i < 8; i++) begin
         if (v.rw) slv_sda = ~v.d[7-i];
         wait_scl(1, ok); all &= ok;
         cap = {cap[6:0], SDA};
         wait_scl(0, ok); all &= ok;
      end
      slv_sda = v.rw ? 1'b0 : ~v.nack;
      wait_scl(1, ok); all &= ok;
      if (v.rw) chk("read_ack_sda", SDA, v.ak);
      wait_scl(0, ok); all &= ok;
      slv_sda = 0;
      n = 0;
      while (!(v.rw ? rx_done : tx_done) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk("scl_timeout", all, 1);
      chk("done_seen", n < 3000, 1);
      if (!v.rw) chk("write_latency", cyc - t0, 9000 + extra);
      e = sb.pop_front();
      if (v.rw) chk("rx_data", rx_data, e);
      else      chk("slave_byte", cap, e);
      st_at = -1;
      @(negedge clk);
      chk("done_pulse", v.rw ? rx_done : tx_done, 0);
   endtask

   initial begin
      vec_t tab[14];
      vec_t v;
      bit on_bus;
      bit ok;
      bit fell;
      bit dropped;
      bit seen;
      int t0;
      int rises;
      logic ps;

      tab[0]  = '{1, 0, 0, 0, 0, 0, 8'h00};
      tab[1]  = '{0, 0, 0, 0, 0, 0, 8'hA6};
      tab[2]  = '{0, 1, 0, 0, 0, 0, 8'h00};
      tab[3]  = '{1, 0, 0, 0, 0, 0, 8'h00};
      tab[4]  = '{0, 0, 0, 0, 1, 1, 8'h51};
      tab[5]  = '{0, 1, 0, 0, 0, 1, 8'h00};
      tab[6]  = '{1, 0, 0, 0, 0, 0, 8'h00};
      tab[7]  = '{0, 0, 0, 0, 0, 0, 8'h5A};
      tab[8]  = '{1, 1, 0, 0, 0, 0, 8'h00};
      tab[9]  = '{1, 0, 0, 0, 0, 0, 8'h00};
      tab[10] = '{0, 0, 1, 1, 0, 0, 8'h3C};
      tab[11] = '{0, 1, 0, 0, 0, 0, 8'h00};
      tab[12] = '{0, 0, 0, 0, 0, 0, 8'h77};
      tab[13] = '{1, 1, 0, 0, 0, 0, 8'h00};

      repeat (3) @(negedge clk);
      chk("rst_tx_ready", tx_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_sda", SDA, 1);
      chk("rst_scl", SCL, 1);
      chk("rst_ack_err", ack_err, 0);
      chk("rst_rx_data", rx_data, 8'h00);
      chk("rst_tx_done", tx_done, 0);
      reset = 0;
      @(negedge clk);

      on_bus = 0;
      for (int r = 0; r < 14; r++) begin
         v = tab[r];
         if ((v.st && v.sp) || (!on_bus && !v.st)) begin
            issue(v.st, v.sp, v.rw, v.ak, v.d, t0);
            chk("ignored_ready", tx_ready, 1);
            chk("ignored_busy", busy, on_bus);
         end else if (v.st) begin
            issue(v.st, v.sp, v.rw, v.ak, v.d, t0);
            chk("start_ready_drop", tx_ready, 0);
            chk("start_clr_err", ack_err, 0);
            wait_ready(ok, fell, dropped);
            chk("start_timeout", ok, 1);
            chk("start_sda_fall", fell, 1);
            chk("start_busy_held", dropped, 0);
            chk("hold_scl_low", SCL, 0);
            on_bus = 1;
         end else if (v.sp) begin
            issue(v.st, v.sp, v.rw, v.ak, v.d, t0);
            chk("stop_ready_drop", tx_ready, 0);
            wait_ready(ok, fell, dropped);
            chk("stop_timeout", ok, 1);
            chk("stop_busy", busy, 0);
            chk("stop_sda", SDA, 1);
            chk("stop_scl", SCL, 1);
            on_bus = 0;
         end else begin
            do_byte(v, 0);
         end
         chk("row_ack_err", ack_err, v.err);
      end

      // Reset during bit 5 of a write aborts with no STOP and no tx_done.
      issue(1, 0, 0, 0, 8'h00, t0);
      wait_ready(ok, fell, dropped);
      issue(0, 0, 0, 0, 8'hC3, t0);
      rises = 0;
      ps = SCL;
      for (int i = 0; i < 8000 && rises < 6; i++) begin
         @(negedge clk);
         if (ps === 1'b0 && SCL === 1'b1) rises++;
         ps = SCL;
      end
      chk("abort_reached_bit5", rises, 6);
      reset = 1;
      @(negedge clk);
      chk("abort_sda", SDA, 1);
      chk("abort_scl", SCL, 1);
      chk("abort_ready", tx_ready, 1);
      chk("abort_busy", busy, 0);
      reset = 0;
      seen = 0;
      repeat (4000) begin
         @(negedge clk);
         if (tx_done) seen = 1;
      end
      chk("abort_no_done", seen, 0);

`ifdef I2C_CLK_STRETCH_EN
      issue(1, 0, 0, 0, 8'h00, t0);
      wait_ready(ok, fell, dropped);
      chk("stretch_start", ok, 1);
      v = '{0, 0, 0, 0, 0, 0, 8'hA6};
      do_byte(v, 500);
      issue(0, 1, 0, 0, 8'h00, t0);
      wait_ready(ok, fell, dropped);
      chk("stretch_stop_busy", busy, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
